hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//  Pipeline sequencing controller for the 5-stage MIPS core; companion to forwarding control.
//  Handles hazards forwarding cannot resolve:
//  - load-use stalls;
//  - multi-cycle multiply/divide (MDU) occupancy stalls;
//  - branch/jump flushes.
//  Drives PC / IF-ID write enables, ID-EX bubble insertion and per-stage flushes. Sits beside
//  the hazard/forwarding logic in the ID/EX region.
// PARAMETERS
//  MDU_LATENCY  32  cycles from MDU issue (instr in EX) until HI/LO valid; legal range 2..63
//  CNT_W        6   MDU down-counter width; must satisfy 2**CNT_W > MDU_LATENCY
//  STAT_W       16  width of saturating stall-cycle statistics counter
// PORTS
//  clk                    in   1      core clock, rising edge
//  reset                  in   1      asynchronous, active-low reset
//  ctl_mem_read_IDEX_i    in   1      instr in ID/EX is a load
//  reg_rt_IDEX_i          in   5      load destination (rt) in ID/EX
//  reg_rs_IFID_i          in   5      rs of instr in IF/ID
//  reg_rt_IFID_i          in   5      rt of instr in IF/ID
//  mdu_issue_i            in   1      mult/div currently in EX (ID/EX not a bubble)
//  hilo_use_IFID_i        in   1      IF/ID instr is mfhi/mflo/mthi/mtlo or mult/div
//  jump_ID_i              in   1      unconditional jump decoded in ID
//  branch_taken_EXMEM_i   in   1      branch resolved taken in MEM
//  pc_write_o             out  1      PC register enable
//  ifid_write_o           out  1      IF/ID register enable
//  idex_bubble_o          out  1      force ID/EX control fields to zero
//  flush_o                out  3      {EXMEM, IDEX, IFID} synchronous flush
//  mdu_busy_o             out  1      MDU counter nonzero
//  mdu_done_o             out  1      one-cycle pulse, HI/LO becomes valid
//  protocol_err_o         out  1      sticky: mdu_issue_i while busy
//  stall_cycles_o         out  STAT_W saturating count of stalled cycles
// BEHAVIOUR
//  Reset (reset=0, async), all held while asserted:
//  - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, flush_o=3'b111;
//  - mdu_busy_o=0, mdu_done_o=0, protocol_err_o=0, stall_cycles_o=0;
//  - state=S_RUN, counter=0.
//  Output timing: control outputs are Mealy, combinational from registered state + inputs,
//  same cycle. mdu_done_o, protocol_err_o and stall_cycles_o are registered.
//  Load-use: luse = ctl_mem_read_IDEX_i && rt_IDEX!=0 && (rt_IDEX==rs_IFID || rt_IDEX==rt_IFID).
//  FSM states:
//  - S_RUN: counter=0.
//  - S_MDU: counter>0, HI/LO pending.
//  FSM transitions:
//  - S_RUN -> S_MDU on mdu_issue_i; counter loads MDU_LATENCY-1.
//  - S_MDU: counter decrements each cycle.
//  - S_MDU -> S_RUN when counter==1, i.e. the next counter value is 0;
//    mdu_done_o=1 in the first S_RUN cycle.
//  - mdu_issue_i in S_MDU: counter reloads MDU_LATENCY-1, protocol_err_o set until reset.
//  mdu_stall = (state==S_MDU) && hilo_use_IFID_i.
//  stall = luse || mdu_stall.
//  Priority, highest first:
//  1. branch_taken_EXMEM_i:
//     - flush_o=3'b111, pc_write_o=1, ifid_write_o=1, idex_bubble_o=0; overrides any stall.
//     - MDU counter keeps running, since the MDU instr is older than the branch.
//  2. jump_ID_i without stall: flush_o=3'b001, pc_write_o=1, ifid_write_o=1.
//     With stall, the jump waits (stall wins) and its flush is taken on the releasing cycle.
//  3. stall: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, flush_o=0.
//  4. otherwise: pc_write_o=1, ifid_write_o=1, idex_bubble_o=0, flush_o=0.
//  Boundary conditions:
//  - Load-use lasts exactly 1 cycle (the bubble clears ctl_mem_read_IDEX_i); forwarding
//    then supplies the data from MEM/WB.
//  - luse and mdu_stall together: one stall per cycle; release only when both are clear.
//  - stall_cycles_o increments in each cycle where stall && !branch_taken_EXMEM_i;
//    saturates at all-ones, no wrap.
//  - mdu_busy_o = (state==S_MDU).
// STRUCTURE
//  Shared package pipeline_pkg:
//  - FSM state encoding (S_RUN=1'b0, S_MDU=1'b1);
//  - flush bit indices (FL_IFID=0, FL_IDEX=1, FL_EXMEM=2);
//  - REG_ZERO=5'd0.
//  One sub-module: mdu_latency_counter (load / decrement / zero-detect / done pulse).
//  Hazard compare and priority mux stay inline.
// TESTING
//  1. Reset asserted mid-run with counter=17 -> outputs at reset values immediately;
//     counter=0 after release; first cycle after release pc_write_o=1.
//  2. lw $t0 in ID/EX, IF/ID rs=$t0 -> exactly 1 cycle pc_write_o=0, idex_bubble_o=1,
//     stall_cycles_o +1. Same case with rt_IDEX=$zero -> no stall.
//  3. mult issued, MDU_LATENCY=32, mfhi in IF/ID 3 cycles later -> stall held 29 cycles;
//     mdu_done_o pulses 32 cycles after issue; release in that same cycle.
//  4. Load-use stall coincident with branch_taken_EXMEM_i -> flush_o=3'b111, pc_write_o=1,
//     no stall counted.
//  5. jump_ID_i during load-use stall -> 1 stall cycle, then flush_o=3'b001.
//  6. Second mdu_issue_i while busy -> protocol_err_o=1 sticky; counter reloaded to 31.
//     Force 70000 stall cycles -> stall_cycles_o=16'hFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Brief    : Shared encodings for the MIPS pipeline sequencing logic.
// Revision : 1.0
// ============================================================================
package pipeline_pkg;

    localparam logic [0:0] S_RUN = 1'b0;
    localparam logic [0:0] S_MDU = 1'b1;

    localparam int FL_IFID  = 0;
    localparam int FL_IDEX  = 1;
    localparam int FL_EXMEM = 2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $zero never carries a real dependency, so it can never cause a load-use stall.
    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] rt_idex,
        input logic [4:0] rs_ifid,
        input logic [4:0] rt_ifid
    );
        return mem_read && (rt_idex != REG_ZERO) &&
               ((rt_idex == rs_ifid) || (rt_idex == rt_ifid));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_latency_counter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_latency_counter
// Brief    : Load / decrement / last-detect counter with a registered done pulse.
// Revision : 1.0
// ============================================================================
module mdu_latency_counter #(
    parameter int LATENCY = 32,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic last,
    output logic done
);

    localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic             r_done;

    // A reload on the final count restarts the operation, so no done pulse then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                r_count <= C_RELOAD;
            end else if (r_count != '0) begin
                r_count <= r_count - C_ONE;
                if (r_count == C_ONE) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign last = (r_count == C_ONE);
    assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_controller
// Brief    : Load-use / MDU stall and branch/jump flush sequencing for the 5-stage core.
// Revision : 1.0
// ============================================================================
module hazard_stall_controller
    import pipeline_pkg::*;
#(
    parameter int MDU_LATENCY = 32,
    parameter int CNT_W       = 6,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ctl_mem_read_IDEX_i,
    input  logic [4:0]        reg_rt_IDEX_i,
    input  logic [4:0]        reg_rs_IFID_i,
    input  logic [4:0]        reg_rt_IFID_i,
    input  logic              mdu_issue_i,
    input  logic              hilo_use_IFID_i,
    input  logic              jump_ID_i,
    input  logic              branch_taken_EXMEM_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              idex_bubble_o,
    output logic [2:0]        flush_o,
    output logic              mdu_busy_o,
    output logic              mdu_done_o,
    output logic              protocol_err_o,
    output logic [STAT_W-1:0] stall_cycles_o
);

    logic [0:0]        r_state;
    logic [0:0]        w_next_state;
    logic              w_cnt_last;
    logic              w_luse;
    logic              w_mdu_stall;
    logic              w_stall;
    logic              r_protocol_err;
    logic [STAT_W-1:0] r_stall_cycles;

    mdu_latency_counter #(
        .LATENCY (MDU_LATENCY),
        .CNT_W   (CNT_W)
    ) u_mdu_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (mdu_issue_i),
        .last  (w_cnt_last),
        .done  (mdu_done_o)
    );

    assign w_luse      = load_use_hazard(ctl_mem_read_IDEX_i, reg_rt_IDEX_i,
                                         reg_rs_IFID_i, reg_rt_IFID_i);
    assign w_mdu_stall = (r_state == S_MDU) && hilo_use_IFID_i;
    assign w_stall     = w_luse || w_mdu_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN: begin
                if (mdu_issue_i) begin
                    w_next_state = S_MDU;
                end
            end
            S_MDU: begin
                if (!mdu_issue_i && w_cnt_last) begin
                    w_next_state = S_RUN;
                end
            end
            default: w_next_state = S_RUN;
        endcase
    end

    // A taken branch squashes everything younger, so it outranks any stall.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_bubble_o = 1'b0;
        flush_o       = 3'b000;
        if (!reset) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            flush_o       = 3'b111;
        end else if (branch_taken_EXMEM_i) begin
            flush_o[FL_IFID]  = 1'b1;
            flush_o[FL_IDEX]  = 1'b1;
            flush_o[FL_EXMEM] = 1'b1;
        end else if (w_stall) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (jump_ID_i) begin
            flush_o[FL_IFID] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_protocol_err <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            if (mdu_issue_i && (r_state == S_MDU)) begin
                r_protocol_err <= 1'b1;
            end
            if (w_stall && !branch_taken_EXMEM_i && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + STAT_W'(1);
            end
        end
    end

    assign mdu_busy_o     = (r_state == S_MDU);
    assign protocol_err_o = r_protocol_err;
    assign stall_cycles_o = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_controller
// Brief    : Vector table plus multi-cycle sequences with an expectation queue.
// Revision : 1.0
// ============================================================================
module tb_hazard_stall_controller;

    typedef struct {
        logic       mem_read;
        logic [4:0] rt_idex;
        logic [4:0] rs_ifid;
        logic [4:0] rt_ifid;
        logic       issue;
        logic       hilo;
        logic       jump;
        logic       branch;
        logic       pc;
        logic       ifid;
        logic       bubble;
        logic [2:0] flush;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctl_mem_read_IDEX_i;
    logic [4:0]  reg_rt_IDEX_i;
    logic [4:0]  reg_rs_IFID_i;
    logic [4:0]  reg_rt_IFID_i;
    logic        mdu_issue_i;
    logic        hilo_use_IFID_i;
    logic        jump_ID_i;
    logic        branch_taken_EXMEM_i;
    logic        pc_write_o;
    logic        ifid_write_o;
    logic        idex_bubble_o;
    logic [2:0]  flush_o;
    logic        mdu_busy_o;
    logic        mdu_done_o;
    logic        protocol_err_o;
    logic [15:0] stall_cycles_o;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_stall = 0;
    vec_t exp_q[$];
    vec_t tbl[12];

    always #5 clk = ~clk;

    hazard_stall_controller dut (
        .clk                  (clk),
        .reset                (reset),
        .ctl_mem_read_IDEX_i  (ctl_mem_read_IDEX_i),
        .reg_rt_IDEX_i        (reg_rt_IDEX_i),
        .reg_rs_IFID_i        (reg_rs_IFID_i),
        .reg_rt_IFID_i        (reg_rt_IFID_i),
        .mdu_issue_i          (mdu_issue_i),
        .hilo_use_IFID_i      (hilo_use_IFID_i),
        .jump_ID_i            (jump_ID_i),
        .branch_taken_EXMEM_i (branch_taken_EXMEM_i),
        .pc_write_o           (pc_write_o),
        .ifid_write_o         (ifid_write_o),
        .idex_bubble_o        (idex_bubble_o),
        .flush_o              (flush_o),
        .mdu_busy_o           (mdu_busy_o),
        .mdu_done_o           (mdu_done_o),
        .protocol_err_o       (protocol_err_o),
        .stall_cycles_o       (stall_cycles_o)
    );

    function automatic vec_t mk(
        input logic mr, input logic [4:0] rti, input logic [4:0] rsi, input logic [4:0] rti2,
        input logic iss, input logic hl, input logic jp, input logic br,
        input logic pc, input logic fw, input logic bub, input logic [2:0] fl,
        input logic busy, input logic done, input logic err
    );
        vec_t v;
        v.mem_read = mr;  v.rt_idex = rti; v.rs_ifid = rsi; v.rt_ifid = rti2;
        v.issue = iss;    v.hilo = hl;     v.jump = jp;     v.branch = br;
        v.pc = pc;        v.ifid = fw;     v.bubble = bub;  v.flush = fl;
        v.busy = busy;    v.done = done;   v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        ctl_mem_read_IDEX_i  = v.mem_read;
        reg_rt_IDEX_i        = v.rt_idex;
        reg_rs_IFID_i        = v.rs_ifid;
        reg_rt_IFID_i        = v.rt_ifid;
        mdu_issue_i          = v.issue;
        hilo_use_IFID_i      = v.hilo;
        jump_ID_i            = v.jump;
        branch_taken_EXMEM_i = v.branch;
    endtask

    // Called 1 time unit after a rising edge; returns at the same point of the next cycle.
    task automatic step(input vec_t v, input string nm);
        vec_t e;
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({nm, ".pc_write"},   32'(pc_write_o),     32'(e.pc));
        chk({nm, ".ifid_write"}, 32'(ifid_write_o),   32'(e.ifid));
        chk({nm, ".bubble"},     32'(idex_bubble_o),  32'(e.bubble));
        chk({nm, ".flush"},      32'(flush_o),        32'(e.flush));
        chk({nm, ".busy"},       32'(mdu_busy_o),     32'(e.busy));
        chk({nm, ".done"},       32'(mdu_done_o),     32'(e.done));
        chk({nm, ".perr"},       32'(protocol_err_o), 32'(e.err));
        if (e.bubble) exp_stall = (exp_stall >= 65535) ? 65535 : exp_stall + 1;
        @(posedge clk);
        #1;
        chk({nm, ".stat"}, 32'(stall_cycles_o), 32'(exp_stall));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".pc_write"},   32'(pc_write_o),     32'd0);
        chk({nm, ".ifid_write"}, 32'(ifid_write_o),   32'd0);
        chk({nm, ".bubble"},     32'(idex_bubble_o),  32'd1);
        chk({nm, ".flush"},      32'(flush_o),        32'd7);
        chk({nm, ".busy"},       32'(mdu_busy_o),     32'd0);
        chk({nm, ".done"},       32'(mdu_done_o),     32'd0);
        chk({nm, ".perr"},       32'(protocol_err_o), 32'd0);
        chk({nm, ".stat"},       32'(stall_cycles_o), 32'd0);
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        int   base;
        logic hl, bz, dn, st;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3'b000, 0, 0, 0);
        tbl[0]  = idle;
        tbl[1]  = mk(1, 8, 8, 3, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0);
        tbl[2]  = mk(1, 8, 3, 8, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3'b000, 0, 0, 0);
        tbl[4]  = mk(1, 8, 9, 10, 0, 0, 0, 0, 1, 1, 0, 3'b000, 0, 0, 0);
        tbl[5]  = mk(0, 8, 8, 8, 0, 0, 0, 0, 1, 1, 0, 3'b000, 0, 0, 0);
        tbl[6]  = mk(1, 8, 8, 0, 0, 0, 0, 1, 1, 1, 0, 3'b111, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 3'b001, 0, 0, 0);
        tbl[8]  = mk(1, 9, 1, 9, 0, 0, 1, 0, 0, 0, 1, 3'b000, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 3'b111, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 3'b000, 0, 0, 0);
        tbl[11] = mk(1, 4, 4, 4, 0, 1, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0);

        // Reset state, held while reset is low even with a load-use pattern present.
        reset = 1'b0;
        drive(tbl[1]);
        #13;
        chk_reset_vals("rst0");
        drive(idle);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

        // Load-use lasts one cycle: the bubble removes the load from ID/EX.
        base = exp_stall;
        step(mk(1, 8, 8, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0), "luse.c0");
        step(mk(0, 0, 8, 0, 0, 0, 0, 0, 1, 1, 0, 3'b000, 0, 0, 0), "luse.c1");
        chk("luse.count", 32'(stall_cycles_o) - 32'(base), 32'd1);

        // Jump waits behind a load-use stall, then flushes IF/ID.
        step(mk(1, 8, 8, 0, 0, 0, 1, 0, 0, 0, 1, 3'b000, 0, 0, 0), "jmp.c0");
        step(mk(0, 0, 8, 0, 0, 0, 1, 0, 1, 1, 0, 3'b001, 0, 0, 0), "jmp.c1");

        // Second issue at cycle 5 while busy: sticky error, counter restarts at 31.
        for (int c = 0; c <= 38; c++) begin
            bz = (c >= 1) && (c <= 36);
            dn = (c == 37);
            v  = mk(0, 0, 0, 0, (c == 0) || (c == 5), 0, 0, 0, 1, 1, 0, 3'b000, bz, dn, c >= 6);
            step(v, $sformatf("perr%0d", c));
        end

        // Asynchronous reset in the middle of an MDU operation (counter at 17).
        step(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 3'b000, 0, 0, 1), "rmid.iss");
        for (int c = 1; c <= 14; c++)
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3'b000, 1, 0, 1), $sformatf("rmid%0d", c));
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("rst1");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_stall = 0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 20; c++) step(idle, $sformatf("post%0d", c));

        // mult issued, mfhi reaches IF/ID 3 cycles later: 29 stall cycles, release on done.
        base = exp_stall;
        for (int c = 0; c <= 33; c++) begin
            hl = (c >= 3);
            bz = (c >= 1) && (c <= 31);
            dn = (c == 32);
            st = hl && bz;
            v  = mk(0, 0, 0, 0, c == 0, hl, 0, 0, !st, !st, st, 3'b000, bz, dn, 0);
            step(v, $sformatf("mdu%0d", c));
        end
        chk("mdu.count", 32'(stall_cycles_o) - 32'(base), 32'd29);

        // Saturation of the statistics counter under a continuous stall.
        drive(tbl[1]);
        repeat (65534 - exp_stall) @(posedge clk);
        #1;
        chk("sat.fffe", 32'(stall_cycles_o), 32'hFFFE);
        @(posedge clk);
        #1;
        chk("sat.ffff", 32'(stall_cycles_o), 32'hFFFF);
        repeat (5000) @(posedge clk);
        #1;
        chk("sat.hold", 32'(stall_cycles_o), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
